// File: rtl/pipe_csa_adder.sv
// ---------------------------------------------------------------------------
// pipe_csa_adder
//
// Pipelined carry-select adder. The operands are split into STAGES = WIDTH/SEG
// segments. Stage k resolves segment k: it adds that segment twice, once
// assuming carry 0 and once assuming carry 1. It then selects the right result
// with the carry produced by stage k-1. Stage 0 uses the external ci.
// Each stage registers:
//   - the resolved low segments,
//   - the still-pending high operand bits,
//   - its selected carry,
//   - a valid bit.
// The whole pipeline stalls as one unit when the output stage holds a result
// that downstream is not consuming.
//
// Parameters:
//   WIDTH     operand/sum width (multiple of SEG, at least SEG)
//   SEG       carry-select segment width
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   in_valid  a/b/ci valid this cycle
//   in_ready  block accepts an operand set this cycle
//   a, b, ci  unsigned operands and carry in
//   out_valid sum/co hold a completed result
//   out_ready downstream consumes the result this cycle
//   sum, co   result {co,sum} = a + b + ci
//   ovf       two's-complement overflow (only when CSA_OVF_EN is defined)
//
// Optional feature macro: CSA_OVF_EN adds the ovf output.
// ---------------------------------------------------------------------------
module pipe_csa_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef CSA_OVF_EN
    output logic             ovf,
`endif
    output logic             co
);

    localparam int STAGES = WIDTH / SEG;

    logic stall;
    logic accept;

    // A full, unconsumed output stage freezes every stage at once. Bubbles
    // therefore only collapse while the output is moving. That keeps the
    // control to a single enable.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO_W = (k + 1) * SEG;
        localparam int HI_W = WIDTH - LO_W;

        logic [SEG-1:0]  seg_a;
        logic [SEG-1:0]  seg_b;
        logic            cin;
        logic            vin;
        logic [SEG:0]    sum0;
        logic [SEG:0]    sum1;
        logic [SEG:0]    sel;
        logic [LO_W-1:0] lo_next;
        logic            vld;
        logic            cry;
        logic [LO_W-1:0] lo;

        if (k == 0) begin : g_src
            assign seg_a   = a[SEG-1:0];
            assign seg_b   = b[SEG-1:0];
            assign cin     = ci;
            assign vin     = accept;
            assign lo_next = sel[SEG-1:0];
        end else begin : g_src
            assign seg_a   = g_stage[k-1].g_hi.hi_a[SEG-1:0];
            assign seg_b   = g_stage[k-1].g_hi.hi_b[SEG-1:0];
            assign cin     = g_stage[k-1].cry;
            assign vin     = g_stage[k-1].vld;
            assign lo_next = {sel[SEG-1:0], g_stage[k-1].lo};
        end

        // Both carry hypotheses are computed up front so the only thing on the
        // inter-stage carry path is the final mux.
        assign sum0 = {1'b0, seg_a} + {1'b0, seg_b};
        assign sum1 = {1'b0, seg_a} + {1'b0, seg_b} + (SEG + 1)'(1);
        assign sel  = cin ? sum1 : sum0;

        always_ff @(posedge clk) begin
            if (reset) begin
                vld <= 1'b0;
                cry <= 1'b0;
                lo  <= '0;
            end else if (!stall) begin
                vld <= vin;
                cry <= sel[SEG];
                lo  <= lo_next;
            end
        end

        // Operand bits above this segment travel along until their own stage.
        // The last stage has nothing left to carry forward.
        if (k < STAGES - 1) begin : g_hi
            logic [HI_W-1:0] hi_a;
            logic [HI_W-1:0] hi_b;
            logic [HI_W-1:0] hi_a_next;
            logic [HI_W-1:0] hi_b_next;

            if (k == 0) begin : g_hsrc
                assign hi_a_next = a[WIDTH-1:SEG];
                assign hi_b_next = b[WIDTH-1:SEG];
            end else begin : g_hsrc
                assign hi_a_next = g_stage[k-1].g_hi.hi_a[WIDTH-k*SEG-1:SEG];
                assign hi_b_next = g_stage[k-1].g_hi.hi_b[WIDTH-k*SEG-1:SEG];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    hi_a <= '0;
                    hi_b <= '0;
                end else if (!stall) begin
                    hi_a <= hi_a_next;
                    hi_b <= hi_b_next;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld;
    assign sum       = g_stage[STAGES-1].lo;
    assign co        = g_stage[STAGES-1].cry;

`ifdef CSA_OVF_EN
    // The MSBs of a, b and sum all meet in the last stage's segment. Overflow
    // is therefore registered there, in step with the result it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (!stall) begin
            ovf <= (g_stage[STAGES-1].seg_a[SEG-1] == g_stage[STAGES-1].seg_b[SEG-1]) &&
                   (g_stage[STAGES-1].sel[SEG-1]   != g_stage[STAGES-1].seg_a[SEG-1]);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_csa_adder.sv
// ---------------------------------------------------------------------------
// tb_pipe_csa_adder
//
// Directed bench for pipe_csa_adder. A 16/4 instance covers:
//   - reset,
//   - latency,
//   - wrap-around,
//   - streaming,
//   - stall,
//   - mid-operation reset.
// A 3/1 instance is swept over every a, b, ci combination.
// ---------------------------------------------------------------------------
module tb_pipe_csa_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        co;
`ifdef CSA_OVF_EN
    logic        ovf;
    logic        sm_ovf;
`endif

    logic        sm_in_valid;
    logic        sm_in_ready;
    logic [2:0]  sm_a;
    logic [2:0]  sm_b;
    logic        sm_ci;
    logic        sm_out_valid;
    logic        sm_out_ready;
    logic [2:0]  sm_sum;
    logic        sm_co;

    int checks = 0;
    int errors = 0;

    pipe_csa_adder #(.WIDTH(16), .SEG(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef CSA_OVF_EN
        .ovf       (ovf),
`endif
        .co        (co)
    );

    pipe_csa_adder #(.WIDTH(3), .SEG(1)) dut_small (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (sm_in_valid),
        .in_ready  (sm_in_ready),
        .a         (sm_a),
        .b         (sm_b),
        .ci        (sm_ci),
        .out_valid (sm_out_valid),
        .out_ready (sm_out_ready),
        .sum       (sm_sum),
`ifdef CSA_OVF_EN
        .ovf       (sm_ovf),
`endif
        .co        (sm_co)
    );

    // Hand-computed streaming vectors and their {co,sum}.
    logic [15:0] btA [8] = '{16'h0001, 16'h00FF, 16'h0FFF, 16'h1234,
                             16'h8000, 16'hABCD, 16'hFFFF, 16'h5555};
    logic [15:0] btB [8] = '{16'h0001, 16'h0001, 16'h0001, 16'h4321,
                             16'h8000, 16'h1111, 16'h0001, 16'hAAAA};
    logic        btC [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [16:0] btE [8] = '{17'h00002, 17'h00100, 17'h01000, 17'h05556,
                             17'h10000, 17'h0BCDE, 17'h10000, 17'h10000};

    // Hand-computed stall-test vectors and their {co,sum}.
    logic [15:0] stA [6] = '{16'h0010, 16'h1111, 16'hF000, 16'h0F0F, 16'h2468, 16'h8001};
    logic [15:0] stB [6] = '{16'h0020, 16'h2222, 16'h1000, 16'hF0F0, 16'h1357, 16'h7FFF};
    logic        stC [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [16:0] stE [6] = '{17'h00030, 17'h03333, 17'h10000, 17'h10000, 17'h037BF, 17'h10000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] va,
                                 input logic [15:0] vb, input logic vci);
        in_valid = v;
        a        = va;
        b        = vb;
        ci       = vci;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated transaction, checking the exact latency and the drain.
    task automatic sendOne(input string tag, input logic [15:0] va,
                           input logic [15:0] vb, input logic vci,
                           input logic [15:0] es, input logic ec, input logic eo);
        out_ready = 1'b1;
        applyStimulus(1'b1, va, vb, vci);
        checkOutput({tag, "_in_ready"}, in_ready, 1);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        tick();
        checkOutput({tag, "_early"}, out_valid, 0);
        tick();
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput({tag, "_sum"}, sum, es);
        checkOutput({tag, "_co"}, co, ec);
`ifdef CSA_OVF_EN
        checkOutput({tag, "_ovf"}, ovf, eo);
`endif
        if (eo === 1'bx) $display("[TB] note: unknown ovf expectation for %s", tag);
        tick();
        checkOutput({tag, "_drain"}, out_valid, 0);
    endtask

    int          idx;
    int          ridx;
    int          matched;
    int          vecIdx;
    logic        stallSeen;
    logic        heldValid;
    logic [16:0] heldVal;
    logic [3:0]  smExp;
    logic [3:0]  smQ [$];
    logic [6:0]  smVec;

    initial begin
        reset        = 1'b1;
        out_ready    = 1'b1;
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
        sm_in_valid  = 1'b0;
        sm_a         = '0;
        sm_b         = '0;
        sm_ci        = 1'b0;
        sm_out_ready = 1'b1;

        $display("[TB] reset");
        tick();
        tick();
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_sum", sum, 0);
        checkOutput("reset_co", co, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        reset = 1'b0;
        tick();

        $display("[TB] single transactions");
        sendOne("ones_plus_zero", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        sendOne("ones_plus_ones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        sendOne("pos_overflow",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        sendOne("plain_add",      16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0);

        $display("[TB] back-to-back");
        out_ready = 1'b1;
        for (int t = 0; t < 11; t++) begin
            if (t < 8) applyStimulus(1'b1, btA[t], btB[t], btC[t]);
            else       applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
            #1;
            checkOutput($sformatf("b2b_in_ready_%0d", t), in_ready, 1);
            tick();
            if (t < 2) begin
                checkOutput($sformatf("b2b_idle_%0d", t), out_valid, 0);
            end else if (t >= 3) begin
                checkOutput($sformatf("b2b_valid_%0d", t - 3), out_valid, 1);
                checkOutput($sformatf("b2b_res_%0d", t - 3), {co, sum}, btE[t - 3]);
            end
        end
        tick();
        checkOutput("b2b_drain", out_valid, 0);

        $display("[TB] stall");
        idx       = 0;
        ridx      = 0;
        stallSeen = 1'b0;
        heldValid = 1'b0;
        heldVal   = '0;
        for (int cyc = 0; cyc < 40 && ridx < 6; cyc++) begin
            out_ready = (cyc >= 6);
            if (idx < 6) applyStimulus(1'b1, stA[idx], stB[idx], stC[idx]);
            else         applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
            #1;
            if (heldValid) checkOutput($sformatf("stall_hold_%0d", cyc), {co, sum}, heldVal);
            heldValid = 1'b0;
            if (out_valid && !out_ready) begin
                stallSeen = 1'b1;
                checkOutput($sformatf("stall_in_ready_%0d", cyc), in_ready, 0);
                heldVal   = {co, sum};
                heldValid = 1'b1;
            end
            if (out_valid && out_ready) begin
                checkOutput($sformatf("stall_res_%0d", ridx), {co, sum}, stE[ridx]);
                ridx++;
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        checkOutput("stall_seen", stallSeen, 1);
        checkOutput("stall_retired", ridx, 6);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
        for (int t = 0; t < 4; t++) begin
            tick();
            checkOutput($sformatf("stall_no_dup_%0d", t), out_valid, 0);
        end

        $display("[TB] reset mid-operation");
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h0001, 16'h0002, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h0003, 16'h0004, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h0005, 16'h0006, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        tick();
        checkOutput("rst_pre_valid", out_valid, 1);
        checkOutput("rst_pre_in_ready", in_ready, 0);
        reset = 1'b1;
        applyStimulus(1'b1, 16'h1234, 16'h1111, 1'b1);
        tick();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_sum", sum, 0);
        checkOutput("rst_co", co, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        reset     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
        for (int t = 0; t < 8; t++) begin
            tick();
            checkOutput($sformatf("rst_flushed_%0d", t), out_valid, 0);
        end

        $display("[TB] exhaustive sweep WIDTH=3 SEG=1");
        matched      = 0;
        vecIdx       = 0;
        sm_out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && matched < 128; cyc++) begin
            if (vecIdx < 128) begin
                smVec       = vecIdx[6:0];
                sm_in_valid = 1'b1;
                sm_a        = smVec[2:0];
                sm_b        = smVec[5:3];
                sm_ci       = smVec[6];
            end else begin
                sm_in_valid = 1'b0;
            end
            #1;
            if (sm_out_valid) begin
                if (smQ.size() == 0) begin
                    checkOutput($sformatf("sweep_spurious_%0d", cyc), 1, 0);
                end else begin
                    smExp = smQ.pop_front();
                    checkOutput($sformatf("sweep_res_%0d", matched), {sm_co, sm_sum}, smExp);
                    matched++;
                end
            end
            if (sm_in_valid && sm_in_ready) begin
                smQ.push_back({1'b0, sm_a} + {1'b0, sm_b} + {3'b000, sm_ci});
                vecIdx++;
            end
            tick();
        end
        sm_in_valid = 1'b0;
        checkOutput("sweep_count", matched, 128);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
